adc_spi_scan: RTL and testbench

Parametrised SPI master for serial multi-channel ADCs. It autonomously scans a masked list of channels, in single-pass or continuous mode. It pipelines addressing: frame k carries the address of the next channel and returns the data for the channel addressed in frame k-1, so it needs only N+1 frames for N channels. Results leave through a valid/ready port with channel tag and overrun flag. It sits between the audio/control sampling logic and the off-chip ADC pins.

---
 rtl/adc_spi_pkg.sv | 26 ++
 rtl/adc_spi_scan_if.sv | 15 +
 rtl/adc_spi_frame.sv | 106 ++++++++++
 rtl/adc_spi_scan.sv | 138 +++++++++++++
 tb/tb_adc_spi_scan.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/adc_spi_pkg.sv
// Shared types and helpers for the scanning SPI ADC master: state encoding,
// default geometry and TX frame construction.
package adc_spi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FRONT = 3'd1,
    ST_SHIFT = 3'd2,
    ST_BACK  = 3'd3,
    ST_GAP   = 3'd4
  } adc_state_e;

  localparam int DEF_DATA_W   = 12;
  localparam int DEF_FRAME_W  = 16;
  localparam int DEF_NUM_CH   = 8;
  localparam int DEF_ADDR_LSB = 11;
  localparam int DEF_SCLK_DIV = 32;
  localparam int MAX_FRAME_W  = 32;

  // TX word is all zeros except the channel field starting at addr_lsb.
  function automatic logic [MAX_FRAME_W-1:0] build_frame(input int unsigned ch,
                                                         input int unsigned addr_lsb);
    return MAX_FRAME_W'(ch) << addr_lsb;
  endfunction

endpackage

// File: rtl/adc_spi_scan_if.sv
// Result port of the ADC scanner. Handshake: result/result_ch are valid while
// result_valid is high and are consumed on a clock where result_valid && result_ready.
interface adc_spi_scan_if #(
  parameter int DATA_W = 12,
  parameter int CH_W   = 3
);
  logic [DATA_W-1:0] result;
  logic [CH_W-1:0]   result_ch;
  logic              result_valid;
  logic              result_ready;
  logic              overrun;

  modport master (output result, result_ch, result_valid, overrun, input result_ready);
  modport slave  (input result, result_ch, result_valid, overrun, output result_ready);
endinterface

// File: rtl/adc_spi_frame.sv
// One SS_n-low SPI frame: FRONT, FRAME_W SCLK bit periods, BACK, GAP. Frames chain
// back-to-back when i_next is high at the end of GAP.
module adc_spi_frame
  import adc_spi_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_start,
  input  logic               i_next,
  input  logic [FRAME_W-1:0] i_tx,
  input  logic               i_miso,
  output logic               o_sclk,
  output logic               o_mosi,
  output logic               o_ss_n,
  output logic [DATA_W-1:0]  o_rx,
  output logic               o_done,
  output logic               o_gap_end,
  output logic [2:0]         o_state
);

  localparam int DIV_W = $clog2(SCLK_DIV);
  localparam int BIT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [DIV_W-1:0] HALF_V   = DIV_W'(SCLK_DIV / 2);
  localparam logic [DIV_W-1:0] HALF_M1  = DIV_W'(SCLK_DIV / 2 - 1);
  localparam logic [DIV_W-1:0] FULL_M1  = DIV_W'(SCLK_DIV - 1);
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(FRAME_W - 1);

  localparam logic [2:0] S_IDLE  = ST_IDLE;
  localparam logic [2:0] S_FRONT = ST_FRONT;
  localparam logic [2:0] S_SHIFT = ST_SHIFT;
  localparam logic [2:0] S_BACK  = ST_BACK;
  localparam logic [2:0] S_GAP   = ST_GAP;

  logic [2:0]         r_state;
  logic [DIV_W-1:0]   r_div;
  logic [BIT_W-1:0]   r_bit;
  logic [FRAME_W-1:0] r_tx;
  logic [DATA_W-1:0]  r_rx;
  logic               w_half_end;
  logic               w_full_end;
  logic               w_sel;

  assign w_half_end = (r_div == HALF_M1);
  assign w_full_end = (r_div == FULL_M1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_div   <= '0;
      r_bit   <= '0;
      r_tx    <= '0;
      r_rx    <= '0;
    end else begin
      case (r_state)
        S_IDLE: if (i_start) begin
          r_state <= S_FRONT;
          r_div   <= '0;
          r_tx    <= i_tx;
        end
        S_FRONT: if (w_half_end) begin
          r_state <= S_SHIFT;
          r_div   <= '0;
          r_bit   <= '0;
        end else r_div <= r_div + 1'b1;
        S_SHIFT: begin
          // RX only keeps the trailing DATA_W bits; earlier bits fall off the top.
          if (w_half_end) r_rx <= {r_rx[DATA_W-2:0], i_miso};
          if (w_full_end) begin
            r_div <= '0;
            if (r_bit == LAST_BIT) r_state <= S_BACK;
            else begin
              r_bit <= r_bit + 1'b1;
              r_tx  <= {r_tx[FRAME_W-2:0], 1'b0};
            end
          end else r_div <= r_div + 1'b1;
        end
        S_BACK: if (w_half_end) begin
          r_state <= S_GAP;
          r_div   <= '0;
        end else r_div <= r_div + 1'b1;
        S_GAP: if (w_half_end) begin
          r_div <= '0;
          if (i_next) begin
            r_state <= S_FRONT;
            r_tx    <= i_tx;
          end else r_state <= S_IDLE;
        end else r_div <= r_div + 1'b1;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign w_sel     = (r_state == S_FRONT) || (r_state == S_SHIFT) || (r_state == S_BACK);
  assign o_ss_n    = !w_sel;
  assign o_sclk    = !((r_state == S_SHIFT) && (r_div < HALF_V));
  assign o_mosi    = w_sel && r_tx[FRAME_W-1];
  assign o_rx      = r_rx;
  assign o_done    = (r_state == S_BACK) && w_half_end;
  assign o_gap_end = (r_state == S_GAP) && w_half_end;
  assign o_state   = r_state;

endmodule

// File: rtl/adc_spi_scan.sv
// Scanning SPI ADC master: walks the latched channel mask with pipelined addressing
// (each frame returns the previous frame's channel) and presents results on res.
module adc_spi_scan
  import adc_spi_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int FRAME_W  = DEF_FRAME_W,
  parameter int NUM_CH   = DEF_NUM_CH,
  parameter int ADDR_LSB = DEF_ADDR_LSB,
  parameter int SCLK_DIV = DEF_SCLK_DIV
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic              continuous,
  input  logic [NUM_CH-1:0] ch_mask,
  output logic              busy,
  adc_spi_scan_if.master    res,
  output logic              SCLK,
  output logic              MOSI,
  input  logic              MISO,
  output logic              SS_n
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  if (SCLK_DIV < 4 || (SCLK_DIV % 2) != 0 || FRAME_W < DATA_W || DATA_W < 2 ||
      FRAME_W > MAX_FRAME_W || ADDR_LSB + CH_W > FRAME_W) begin : g_bad_params
    $error("adc_spi_scan: illegal parameter combination");
  end

  logic [2:0]         w_state;
  logic               w_idle, w_accept, w_done, w_gap_end;
  logic               w_next, w_next_trail, w_cur_last;
  logic [CH_W-1:0]    w_first_in, w_next_ch, w_tx_ch;
  logic [FRAME_W-1:0] w_tx;
  logic [DATA_W-1:0]  w_rx;

  logic [NUM_CH-1:0]  r_mask;
  logic               r_cont, r_first, r_trail, r_stop;
  logic [CH_W-1:0]    r_cur_ch, r_prev_ch;

  assign w_idle   = (w_state == ST_IDLE);
  assign busy     = !w_idle;
  assign w_accept = w_idle && start && (|ch_mask);

  always_comb begin
    w_first_in = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) if (ch_mask[i]) w_first_in = CH_W'(i);
  end

  // Next channel is the lowest set bit above the current one, else wrap to lowest.
  always_comb begin
    w_next_ch  = '0;
    w_cur_last = 1'b1;
    for (int i = NUM_CH - 1; i >= 0; i--) if (r_mask[i]) w_next_ch = CH_W'(i);
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      if (r_mask[i] && i > int'(r_cur_ch)) begin
        w_next_ch  = CH_W'(i);
        w_cur_last = 1'b0;
      end
    end
  end

  assign w_next       = !r_trail;
  assign w_next_trail = r_stop || stop || (!r_cont && w_cur_last);
  assign w_tx_ch      = w_idle ? w_first_in : w_next_ch;
  assign w_tx         = FRAME_W'(build_frame(32'(w_tx_ch), ADDR_LSB));

  adc_spi_frame #(
    .DATA_W  (DATA_W),
    .FRAME_W (FRAME_W),
    .SCLK_DIV(SCLK_DIV)
  ) u_frame (
    .clk      (clk),
    .rst      (rst),
    .i_start  (w_accept),
    .i_next   (w_next),
    .i_tx     (w_tx),
    .i_miso   (MISO),
    .o_sclk   (SCLK),
    .o_mosi   (MOSI),
    .o_ss_n   (SS_n),
    .o_rx     (w_rx),
    .o_done   (w_done),
    .o_gap_end(w_gap_end),
    .o_state  (w_state)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mask    <= '0;
      r_cont    <= 1'b0;
      r_cur_ch  <= '0;
      r_prev_ch <= '0;
      r_first   <= 1'b0;
      r_trail   <= 1'b0;
      r_stop    <= 1'b0;
    end else if (w_accept) begin
      r_mask   <= ch_mask;
      r_cont   <= continuous;
      r_cur_ch <= w_first_in;
      r_first  <= 1'b1;
      r_trail  <= 1'b0;
      r_stop   <= 1'b0;
    end else begin
      if (stop && busy) r_stop <= 1'b1;
      if (w_gap_end && w_next) begin
        r_prev_ch <= r_cur_ch;
        r_cur_ch  <= w_next_ch;
        r_first   <= 1'b0;
        r_trail   <= w_next_trail;
      end
    end
  end

  // Frame 0 carries no valid data; every later frame delivers the previous channel.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      res.result       <= '0;
      res.result_ch    <= '0;
      res.result_valid <= 1'b0;
      res.overrun      <= 1'b0;
    end else begin
      if (w_accept) res.overrun <= 1'b0;
      if (w_done && !r_first) begin
        res.result       <= w_rx;
        res.result_ch    <= r_prev_ch;
        res.result_valid <= 1'b1;
        if (res.result_valid && !res.result_ready) res.overrun <= 1'b1;
      end else if (res.result_valid && res.result_ready) begin
        res.result_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_adc_spi_scan.sv
// Directed bench for adc_spi_scan at default geometry with a behavioural ADC that
// echoes 12'h100 + previously addressed channel.
module tb_adc_spi_scan;

  localparam int DATA_W     = 12;
  localparam int FRAME_W    = 16;
  localparam int NUM_CH     = 8;
  localparam int CH_W       = 3;
  localparam int ADDR_LSB   = 11;
  localparam int SCLK_DIV   = 32;
  localparam int FRAME_CLKS = FRAME_W * SCLK_DIV + 3 * SCLK_DIV / 2;

  logic              clk = 1'b0;
  logic              rst;
  logic              start, stop, continuous;
  logic [NUM_CH-1:0] ch_mask;
  logic              busy, SCLK, MOSI, SS_n;
  logic              MISO = 1'b0;

  adc_spi_scan_if #(.DATA_W(DATA_W), .CH_W(CH_W)) res_if ();

  adc_spi_scan #(
    .DATA_W(DATA_W), .FRAME_W(FRAME_W), .NUM_CH(NUM_CH),
    .ADDR_LSB(ADDR_LSB), .SCLK_DIV(SCLK_DIV)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .stop(stop), .continuous(continuous),
    .ch_mask(ch_mask), .busy(busy), .res(res_if.master),
    .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO), .SS_n(SS_n)
  );

  // clock / reset block
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_bad    = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=0x%0h exp=0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // ADC model: shifts MOSI in on SCLK rise, drives MISO on SCLK fall
  bit          frame_en = 1'b0;
  int          falls = 0;
  int          nframes = 0;
  int          ss_falls = 0;
  logic [15:0] out_word = '0;
  logic [15:0] rx_in = '0;
  logic [2:0]  last_addr = '0;
  logic [15:0] exp_tx_q[$];

  always @(negedge SS_n) begin
    falls    = 0;
    rx_in    = '0;
    ss_falls++;
    out_word = {4'h0, 12'h100 + {9'd0, last_addr}};
  end
  always @(negedge SCLK) if (SS_n === 1'b0) begin
    MISO = out_word[15 - falls];
    falls++;
  end
  always @(posedge SCLK) if (SS_n === 1'b0) rx_in = {rx_in[14:0], MOSI};
  always @(posedge SS_n) if (frame_en) begin
    check("falls_per_frame", falls, 16);
    check("tx_pending", exp_tx_q.size() > 0, 1);
    if (exp_tx_q.size() > 0) check("tx_word", rx_in, exp_tx_q.pop_front());
    last_addr = rx_in[13:11];
    nframes++;
  end

  // SPI timing monitor, sampled mid-cycle
  bit   en_mon = 1'b0;
  bit   pend_first = 1'b0;
  bit   gap_valid = 1'b0;
  logic p_sclk = 1'b1, p_ss = 1'b1, p_mosi = 1'b0;
  int   t_ss_fall = 0, t_ss_rise = 0, t_fall = 0;

  always @(negedge clk) begin
    if (en_mon) begin
      if (p_ss && !SS_n) begin
        t_ss_fall  = cyc;
        pend_first = 1'b1;
        if (gap_valid) check("ss_high_gap", cyc - t_ss_rise, 16);
      end
      if (!p_ss && SS_n) begin
        t_ss_rise = cyc;
        gap_valid = 1'b1;
      end
      if (p_sclk && !SCLK) begin
        if (pend_first) begin
          check("ss_to_first_fall", cyc - t_ss_fall, 16);
          pend_first = 1'b0;
        end else check("sclk_period", cyc - t_fall, 32);
        t_fall = cyc;
      end
      if (!p_sclk && SCLK && !SS_n) check("sclk_low_half", cyc - t_fall, 16);
      if (!SS_n && !p_ss && MOSI !== p_mosi) check("mosi_on_fall", p_sclk && !SCLK, 1);
      if (!busy) gap_valid = 1'b0;
    end else begin
      pend_first = 1'b0;
      gap_valid  = 1'b0;
    end
    p_sclk = SCLK;
    p_ss   = SS_n;
    p_mosi = MOSI;
  end

  // scoreboard on the result port
  logic [CH_W+DATA_W-1:0] exp_q[$];

  always @(negedge clk) if (!rst && res_if.result_valid && res_if.result_ready) begin
    check("result_pending", exp_q.size() > 0, 1);
    if (exp_q.size() > 0) check("result", {res_if.result_ch, res_if.result}, exp_q.pop_front());
  end

  // driver tasks
  int t_start = 0;

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_start(input logic [NUM_CH-1:0] m, input logic c, input logic s);
    ch_mask    = m;
    continuous = c;
    stop       = s;
    start      = 1'b1;
    t_start    = cyc + 1;
    tick(1);
    start = 1'b0;
    stop  = 1'b0;
  endtask

  task automatic wait_idle(input int max_cyc, output int dur);
    int k = 0;
    while (busy && k < max_cyc) begin
      @(negedge clk);
      k++;
    end
    dur = cyc - t_start;
    check("idle_reached", busy, 0);
    tick(1);
  endtask

  task automatic push_res(input logic [2:0] ch, input logic [11:0] d);
    exp_q.push_back({ch, d});
  endtask

  task automatic end_scan(input string tag, input int frames);
    tick(3);
    check({tag, "_frames"}, nframes, frames);
    check({tag, "_tx_drained"}, exp_tx_q.size(), 0);
    check({tag, "_res_drained"}, exp_q.size(), 0);
    nframes = 0;
  endtask

  initial begin
    #3ms;
    $display("FAIL watchdog total=%0d bad=%0d", n_checks, n_bad);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int dur;
    int k;
    int sf;
    rst = 1'b1; start = 1'b0; stop = 1'b0; continuous = 1'b0; ch_mask = '0;
    res_if.result_ready = 1'b1;
    tick(2);
    check("rst_ss_n", SS_n, 1);
    check("rst_sclk", SCLK, 1);
    check("rst_mosi", MOSI, 0);
    check("rst_busy", busy, 0);
    check("rst_valid", res_if.result_valid, 0);
    check("rst_result", res_if.result, 0);
    check("rst_result_ch", res_if.result_ch, 0);
    check("rst_overrun", res_if.overrun, 0);
    rst = 1'b0;
    tick(3);
    en_mon = 1'b1;
    frame_en = 1'b1;

    // single pass, channels 2 and 5
    exp_tx_q = '{16'h1000, 16'h2800, 16'h1000};
    push_res(3'd2, 12'h102);
    push_res(3'd5, 12'h105);
    do_start(8'h24, 1'b0, 1'b0);
    check("sp_busy_rise", busy, 1);
    wait_idle(3 * FRAME_CLKS + 100, dur);
    check("sp_busy_clks", dur, 1680);
    end_scan("sp", 3);

    // continuous 0x81, stop during the fifth frame
    exp_tx_q = '{16'h0000, 16'h3800, 16'h0000, 16'h3800, 16'h0000, 16'h3800};
    push_res(3'd0, 12'h100); push_res(3'd7, 12'h107); push_res(3'd0, 12'h100);
    push_res(3'd7, 12'h107); push_res(3'd0, 12'h100);
    do_start(8'h81, 1'b1, 1'b0);
    k = 0;
    while (nframes < 4 && k < 5 * FRAME_CLKS) begin
      @(negedge clk);
      k++;
    end
    check("cont_frames_before_stop", nframes, 4);
    tick(100);
    stop = 1'b1;
    tick(1);
    stop = 1'b0;
    wait_idle(3 * FRAME_CLKS, dur);
    check("cont_busy_clks", dur, 6 * FRAME_CLKS);
    end_scan("cont", 6);

    // backpressure: two results with no consumer
    res_if.result_ready = 1'b0;
    exp_tx_q = '{16'h1000, 16'h2800, 16'h1000};
    do_start(8'h24, 1'b0, 1'b0);
    wait_idle(3 * FRAME_CLKS + 100, dur);
    check("bp_valid_held", res_if.result_valid, 1);
    check("bp_result", res_if.result, 12'h105);
    check("bp_result_ch", res_if.result_ch, 5);
    check("bp_overrun", res_if.overrun, 1);
    push_res(3'd5, 12'h105);
    res_if.result_ready = 1'b1;
    tick(3);
    check("bp_valid_drop", res_if.result_valid, 0);
    check("bp_overrun_sticky", res_if.overrun, 1);
    end_scan("bp", 3);
    exp_tx_q = '{16'h0000, 16'h0000};
    push_res(3'd0, 12'h100);
    do_start(8'h01, 1'b0, 1'b0);
    tick(2);
    check("bp_overrun_cleared", res_if.overrun, 0);
    wait_idle(2 * FRAME_CLKS + 100, dur);
    check("single_ch_busy_clks", dur, 1120);
    end_scan("one_ch", 2);

    // reset in the middle of the third frame's SHIFT phase
    res_if.result_ready = 1'b0;
    frame_en = 1'b0;
    do_start(8'hFF, 1'b1, 1'b0);
    tick(1300);
    check("pre_rst_valid", res_if.result_valid, 1);
    check("pre_rst_sclk_low", SCLK, 0);
    en_mon = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_ss_n", SS_n, 1);
    check("mid_rst_sclk", SCLK, 1);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_valid", res_if.result_valid, 0);
    tick(2);
    rst = 1'b0;
    res_if.result_ready = 1'b1;
    tick(2);
    check("post_rst_result", res_if.result, 0);
    check("post_rst_result_ch", res_if.result_ch, 0);
    nframes = 0;
    en_mon = 1'b1;
    frame_en = 1'b1;
    exp_tx_q = '{16'h1000, 16'h2800, 16'h1000};
    push_res(3'd2, 12'h102);
    push_res(3'd5, 12'h105);
    do_start(8'h24, 1'b0, 1'b0);
    wait_idle(3 * FRAME_CLKS + 100, dur);
    check("post_rst_busy_clks", dur, 1680);
    end_scan("post_rst", 3);

    // empty mask is ignored
    sf = ss_falls;
    do_start(8'h00, 1'b1, 1'b0);
    tick(50);
    check("mask0_busy", busy, 0);
    check("mask0_no_ss", ss_falls - sf, 0);

    // start+stop together, then a start while busy must not re-latch
    exp_tx_q = '{16'h1000, 16'h2800, 16'h1000};
    push_res(3'd2, 12'h102);
    push_res(3'd5, 12'h105);
    do_start(8'h24, 1'b0, 1'b1);
    tick(100);
    k = t_start;
    do_start(8'hFF, 1'b1, 1'b0);
    t_start = k;
    check("busy_start_held", busy, 1);
    wait_idle(4 * FRAME_CLKS, dur);
    check("busy_start_clks", dur, 1680);
    end_scan("busy_start", 3);

    $display("test done: total=%0d bad=%0d", n_checks, n_bad);
    $finish;
  end

endmodule
